// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   state_e : arbiter FSM encoding (IDLE / OWNED)
//   clog2   : ceiling log2, floored at 1 so the result is always a legal width
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority encoder.
//   req_valid_i : per-requester request bits
//   rr_ptr_i    : index holding highest priority (must be < N_REQ)
//   any_valid_o : at least one request present
//   winner_o    : first valid index in order ptr, ptr+1, ..., N_REQ-1, 0, ...
module rr_priority_pick #(
  parameter int N_REQ    = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [N_REQ-1:0]    req_valid_i,
  input  logic [ID_WIDTH-1:0] rr_ptr_i,
  output logic                any_valid_o,
  output logic [ID_WIDTH-1:0] winner_o
);

  logic [N_REQ-1:0]  rot;
  logic [ID_WIDTH:0] off;
  logic [ID_WIDTH:0] sum;

  always_comb begin
    // Doubling the vector makes the right shift a rotation, so rot[k] is
    // the request k places after the pointer.
    rot = N_REQ'({req_valid_i, req_valid_i} >> rr_ptr_i);
    off = '0;
    // Scan downward so the smallest offset is the one left standing.
    for (int k = N_REQ - 1; k >= 0; k--)
      if (rot[k]) off = (ID_WIDTH + 1)'(k);
    // Modular add that works for non-power-of-two N_REQ.
    sum = {1'b0, rr_ptr_i} + off;
    if (sum >= (ID_WIDTH + 1)'(N_REQ)) sum = sum - (ID_WIDTH + 1)'(N_REQ);
    winner_o    = sum[ID_WIDTH-1:0];
    any_valid_o = |req_valid_i;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port among N_REQ producers with round-robin
// arbitration and a bounded burst per grant.
//   clk, reset        : rising-edge clock, async active-low reset
//   req_valid/data    : per-requester word and its valid (data packed by index)
//   req_ack           : one-hot, word consumed this cycle (combinational)
//   fifo_full         : FIFO full flag; no write is issued while it is high
//   fifo_d_in/w_en    : FIFO write port
//   grant_id          : requester being served (tags the written word)
//   busy              : a requester currently owns the port
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int D_WIDTH   = 8,
  parameter int ID_WIDTH  = 2,
  parameter int BURST_MAX = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*D_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]         req_ack,
  input  logic                     fifo_full,
  output logic [D_WIDTH-1:0]       fifo_d_in,
  output logic                     fifo_w_en,
  output logic [ID_WIDTH-1:0]      grant_id,
  output logic                     busy
);

  localparam int CW = clog2(BURST_MAX + 1);

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] owner_q, owner_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]       burst_cnt_q, burst_cnt_d;

  logic                pick_any;
  logic [ID_WIDTH-1:0] pick_win;
  logic                own_valid;

  logic                w_en;
  logic [N_REQ-1:0]    ack;
  logic [D_WIDTH-1:0]  d_out;
  logic [ID_WIDTH-1:0] gid;

  rr_priority_pick #(
    .N_REQ    (N_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .any_valid_o (pick_any),
    .winner_o    (pick_win)
  );

  function automatic logic [ID_WIDTH-1:0] next_idx(input logic [ID_WIDTH-1:0] x);
    return (x == ID_WIDTH'(N_REQ - 1)) ? '0 : x + 1'b1;
  endfunction

  function automatic logic [D_WIDTH-1:0] sel_data(input logic [ID_WIDTH-1:0] sel,
                                                  input logic [N_REQ*D_WIDTH-1:0] d);
    logic [D_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < N_REQ; i++)
      if (ID_WIDTH'(i) == sel) r = d[i*D_WIDTH +: D_WIDTH];
    return r;
  endfunction

  assign own_valid = |(req_valid & (N_REQ'(1) << owner_q));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    w_en        = 1'b0;
    ack         = '0;
    d_out       = '0;
    gid         = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any && !fifo_full) begin
          w_en  = 1'b1;
          ack   = N_REQ'(1) << pick_win;
          d_out = sel_data(pick_win, req_data);
          gid   = pick_win;
          if (BURST_MAX == 1) begin
            rr_ptr_d = next_idx(pick_win);
          end else begin
            state_d     = ST_OWNED;
            owner_d     = pick_win;
            burst_cnt_d = CW'(1);
          end
        end
      end
      ST_OWNED: begin
        gid = owner_q;
        if (!own_valid) begin
          // Owner went away: give up the port, costing one idle cycle.
          state_d     = ST_IDLE;
          rr_ptr_d    = next_idx(owner_q);
          burst_cnt_d = '0;
        end else if (!fifo_full) begin
          w_en        = 1'b1;
          ack         = N_REQ'(1) << owner_q;
          d_out       = sel_data(owner_q, req_data);
          burst_cnt_d = burst_cnt_q + 1'b1;
          // Burst exhausted: IDLE re-arbitrates and transfers in the same
          // cycle, so the handover itself costs no bubble.
          if (burst_cnt_d == CW'(BURST_MAX)) begin
            state_d     = ST_IDLE;
            rr_ptr_d    = next_idx(owner_q);
            burst_cnt_d = '0;
          end
        end
        // fifo_full with owner valid: hold, stall cycles are not counted.
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Outputs are combinational from the inputs, so gate them with reset to
  // keep the FIFO quiet the instant reset asserts.
  assign fifo_w_en = reset & w_en;
  assign req_ack   = ack & {N_REQ{reset}};
  assign fifo_d_in = d_out & {D_WIDTH{reset}};
  assign grant_id  = gid & {ID_WIDTH{reset}};
  assign busy      = reset & (state_q == ST_OWNED);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [3:0]      valid;
  logic [3:0][7:0] rdata;
  logic            full;
  logic [3:0]      ack;
  logic [7:0]      d_in;
  logic            w_en;
  logic [1:0]      gid;
  logic            busy;

  logic [2:0]      valid3;
  logic [2:0][7:0] rdata3;
  logic            full3;
  logic [2:0]      ack3;
  logic [7:0]      d_in3;
  logic            w_en3;
  logic [1:0]      gid3;
  logic            busy3;

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(.N_REQ(4), .D_WIDTH(8), .ID_WIDTH(2), .BURST_MAX(4)) dut (
    .clk(clk), .reset(rst_n), .req_valid(valid), .req_data(rdata), .req_ack(ack),
    .fifo_full(full), .fifo_d_in(d_in), .fifo_w_en(w_en), .grant_id(gid), .busy(busy)
  );

  fifo_wr_arbiter #(.N_REQ(3), .D_WIDTH(8), .ID_WIDTH(2), .BURST_MAX(1)) dut3 (
    .clk(clk), .reset(rst_n), .req_valid(valid3), .req_data(rdata3), .req_ack(ack3),
    .fifo_full(full3), .fifo_d_in(d_in3), .fifo_w_en(w_en3), .grant_id(gid3), .busy(busy3)
  );

  // Reference model: who owns the port, how many beats it has had, and
  // which index has priority next.
  bit         m_owned;
  int         m_owner, m_ptr, m_cnt;
  logic       exp_wen;
  logic [3:0] exp_ack;
  logic [7:0] exp_d;
  logic [1:0] exp_gid;
  logic       exp_busy;

  task automatic m_reset();
    m_owned = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
  endtask

  function automatic int m_pick();
    for (int k = 0; k < N; k++)
      if (valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic m_eval();
    int w;
    exp_wen = 0; exp_ack = '0; exp_d = '0; exp_gid = '0; exp_busy = m_owned;
    if (m_owned) begin
      exp_gid = 2'(m_owner);
      if (valid[m_owner] && !full) begin
        exp_wen = 1; exp_ack[m_owner] = 1'b1; exp_d = rdata[m_owner];
      end
    end else begin
      w = m_pick();
      if (w >= 0 && !full) begin
        exp_wen = 1; exp_ack[w] = 1'b1; exp_d = rdata[w]; exp_gid = 2'(w);
      end
    end
  endtask

  task automatic m_commit();
    int w;
    if (m_owned) begin
      if (!valid[m_owner]) begin
        m_owned = 0; m_ptr = (m_owner + 1) % N;
      end else if (!full) begin
        m_cnt++;
        if (m_cnt == B) begin m_owned = 0; m_ptr = (m_owner + 1) % N; end
      end
    end else begin
      w = m_pick();
      if (w >= 0 && !full) begin
        if (B == 1) m_ptr = (w + 1) % N;
        else begin m_owned = 1; m_owner = w; m_cnt = 1; end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid = '0; valid3 = '0; full = 1'b0; full3 = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 4'hF; valid3 = 3'h7; full = 1'b0; full3 = 1'b0;
    rdata = 32'h44332211; rdata3 = 24'h332211;
    @(negedge clk);
    checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b exp 0", w_en); end
    checks++; if (ack !== 4'h0) begin errors++; $display("FAIL reset_ack: got %b exp 0000", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (gid !== 2'd0 || d_in !== 8'h00) begin errors++; $display("FAIL reset_gid_data: got %0d/%h exp 0/00", gid, d_in); end
    checks++; if (w_en3 !== 1'b0 || ack3 !== 3'h0) begin errors++; $display("FAIL reset_dut3: got wen %b ack %b exp 0/000", w_en3, ack3); end
    do_reset();
  endtask

  // Lone requester: bursts of four, one IDLE cycle that still transfers.
  task automatic test_single();
    do_reset();
    valid = 4'b0100;
    for (int c = 0; c < 6; c++) begin
      rdata[2] = 8'hA0 + 8'(c);
      @(negedge clk);
      checks++;
      if (w_en !== 1'b1 || d_in !== 8'hA0 + 8'(c) || gid !== 2'd2 || ack !== 4'b0100 ||
          busy !== ((c != 0 && c != 4) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL single c%0d: got wen %b d %h gid %0d ack %b busy %b exp 1 %h 2 0100 %b",
                 c, w_en, d_in, gid, ack, busy, 8'hA0 + 8'(c), (c != 0 && c != 4));
      end
      @(posedge clk); #1;
    end
  endtask

  // All busy: 4-beat grants rotate 0,1,2,3,0 with no bubbles.
  task automatic test_all_valid();
    int g;
    do_reset();
    valid = 4'hF;
    for (int i = 0; i < 4; i++) rdata[i] = 8'h10 + 8'(i);
    for (int c = 0; c < 17; c++) begin
      g = (c / 4) % 4;
      @(negedge clk);
      checks++;
      if (w_en !== 1'b1 || gid !== 2'(g) || ack !== 4'(1 << g) || d_in !== 8'h10 + 8'(g)) begin
        errors++;
        $display("FAIL all_valid c%0d: got wen %b gid %0d ack %b d %h exp 1 %0d %b %h",
                 c, w_en, gid, ack, d_in, g, 4'(1 << g), 8'h10 + 8'(g));
      end
      @(posedge clk); #1;
    end
  endtask

  // Full stalls inside a burst do not count toward the burst length.
  task automatic test_full_stall();
    logic fpat [8] = '{0, 0, 1, 1, 1, 0, 0, 0};
    do_reset();
    valid = 4'b0010; rdata[1] = 8'h5A;
    for (int c = 0; c < 8; c++) begin
      full = fpat[c];
      if (c == 7) valid = 4'hF;
      @(negedge clk);
      checks++;
      if (c < 7) begin
        if (w_en !== !fpat[c] || ack !== (fpat[c] ? 4'b0000 : 4'b0010) ||
            busy !== (c != 0) || gid !== 2'd1) begin
          errors++;
          $display("FAIL stall c%0d: got wen %b ack %b busy %b gid %0d exp %b %b %b 1",
                   c, w_en, ack, busy, gid, !fpat[c], fpat[c] ? 4'b0000 : 4'b0010, c != 0);
        end
      end else if (w_en !== 1'b1 || gid !== 2'd2 || busy !== 1'b0 || ack !== 4'b0100) begin
        errors++;
        $display("FAIL stall_next: got wen %b gid %0d busy %b ack %b exp 1 2 0 0100", w_en, gid, busy, ack);
      end
      @(posedge clk); #1;
    end
    full = 1'b0;
  endtask

  // Owner drops valid: one bubble, then priority moves past it.
  task automatic test_release();
    logic [3:0] vv  [4] = '{4'b1001, 4'b1001, 4'b1000, 4'b1000};
    logic       ew  [4] = '{1, 1, 0, 1};
    logic [3:0] ea  [4] = '{4'b0001, 4'b0001, 4'b0000, 4'b1000};
    logic [1:0] eg  [4] = '{2'd0, 2'd0, 2'd0, 2'd3};
    logic       eb  [4] = '{0, 1, 1, 0};
    do_reset();
    rdata = 32'hD3C2B1A0;
    for (int c = 0; c < 4; c++) begin
      valid = vv[c];
      @(negedge clk);
      checks++;
      if (w_en !== ew[c] || ack !== ea[c] || gid !== eg[c] || busy !== eb[c]) begin
        errors++;
        $display("FAIL release c%0d: got wen %b ack %b gid %0d busy %b exp %b %b %0d %b",
                 c, w_en, ack, gid, busy, ew[c], ea[c], eg[c], eb[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Three requesters, single-beat grants: pointer wraps 2 -> 0.
  task automatic test_wrap3();
    do_reset();
    valid3 = 3'h7; rdata3 = 24'h323130;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks++;
      if (w_en3 !== 1'b1 || gid3 !== 2'(c % 3) || ack3 !== 3'(1 << (c % 3)) ||
          d_in3 !== 8'h30 + 8'(c % 3) || busy3 !== 1'b0) begin
        errors++;
        $display("FAIL wrap3 c%0d: got wen %b gid %0d ack %b d %h busy %b exp 1 %0d %b %h 0",
                 c, w_en3, gid3, ack3, d_in3, busy3, c % 3, 3'(1 << (c % 3)), 8'h30 + 8'(c % 3));
      end
      @(posedge clk); #1;
    end
    valid3 = '0;
  endtask

  // Reset mid-burst clears outputs without a clock; arbitration restarts.
  task automatic test_reset_midburst();
    do_reset();
    valid = 4'b0100; rdata = 32'h44332211;
    repeat (2) begin @(posedge clk); #1; end
    #2;
    checks++;
    if (w_en !== 1'b1 || busy !== 1'b1 || gid !== 2'd2) begin
      errors++; $display("FAIL midburst_pre: got wen %b busy %b gid %0d exp 1 1 2", w_en, busy, gid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (w_en !== 1'b0 || ack !== 4'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL midburst_async: got wen %b ack %b busy %b exp 0 0000 0", w_en, ack, busy);
    end
    valid = 4'hF;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (w_en !== 1'b1 || gid !== ((c < 4) ? 2'd0 : 2'd1) ||
          busy !== ((c != 0 && c != 4) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL midburst_after c%0d: got wen %b gid %0d busy %b exp 1 %0d %b",
                 c, w_en, gid, busy, (c < 4) ? 0 : 1, (c != 0 && c != 4));
      end
      @(posedge clk); #1;
    end
  endtask

  // Random traffic and back-pressure against the model.
  task automatic test_random();
    logic [3:0] last_ack;
    do_reset();
    last_ack = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin valid[i] = 1'b1; rdata[i] = 8'($urandom); end
        end else if (last_ack[i]) begin
          valid[i] = ($urandom_range(0, 3) != 0); rdata[i] = 8'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          valid[i] = 1'b0;
        end
      end
      full = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      m_eval();
      checks++;
      if (w_en !== exp_wen || ack !== exp_ack || d_in !== exp_d || gid !== exp_gid || busy !== exp_busy) begin
        errors++;
        $display("FAIL random c%0d: got wen %b ack %b d %h gid %0d busy %b exp %b %b %h %0d %b",
                 c, w_en, ack, d_in, gid, busy, exp_wen, exp_ack, exp_d, exp_gid, exp_busy);
      end
      checks++;
      if (w_en === 1'b1 && full === 1'b1) begin
        errors++; $display("FAIL random_full_write c%0d: got wen 1 with full 1 exp wen 0", c);
      end
      last_ack = exp_ack;
      @(posedge clk);
      m_commit();
      #1;
    end
    full = 1'b0; valid = '0;
  endtask

  initial begin
    rst_n = 1'b0; valid = '0; valid3 = '0; full = 1'b0; full3 = 1'b0;
    rdata = '0; rdata3 = '0;
    m_reset();
    #1;
    test_reset();
    test_single();
    test_all_valid();
    test_full_stall();
    test_release();
    test_wrap3();
    test_reset_midburst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
